// File: rtl/ddr_rx_capture.sv
// DDR receive capture: both clock edges sampled, realigned to posedge, framed onto an AXI-stream style output with exact tlast.
// Optional build macro DDR_RX_CAPTURE_STATS_EN adds frame/error counters. Latency 3 cycles, no backpressure.
module ddr_rx_capture #(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 1518
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   rxd,
  input  logic               rx_ctl,
  output logic [2*WIDTH-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser
`ifdef DDR_RX_CAPTURE_STATS_EN
  ,
  output logic [31:0]        stat_frames,
  output logic [31:0]        stat_errors
`endif
);

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE, DROP} state_t;

  logic [WIDTH-1:0]   rise_dat, fall_dat, al_rise_dat, al_fall_dat;
  logic               rise_ctl, fall_ctl, al_rise_ctl, al_fall_ctl;
  logic               cap_real, al_real;
  logic [2*WIDTH-1:0] hold_dat;
  logic               err_acc;
  logic [15:0]        cnt;
  logic [15:0]        cnt_next;
  state_t             state;

  logic               beat_dv, beat_er;
  logic [2*WIDTH-1:0] beat_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_dat <= '0;
      rise_ctl <= 1'b0;
    end else begin
      rise_dat <= rxd;
      rise_ctl <= rx_ctl;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_dat <= '0;
      fall_ctl <= 1'b0;
    end else begin
      fall_dat <= rxd;
      fall_ctl <= rx_ctl;
    end
  end

  // cap_real/al_real mark when the aligned pair holds real pin samples rather than reset values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_rise_dat <= '0;
      al_fall_dat <= '0;
      al_rise_ctl <= 1'b0;
      al_fall_ctl <= 1'b0;
      cap_real    <= 1'b0;
      al_real     <= 1'b0;
    end else begin
      al_rise_dat <= rise_dat;
      al_fall_dat <= fall_dat;
      al_rise_ctl <= rise_ctl;
      al_fall_ctl <= fall_ctl;
      cap_real    <= 1'b1;
      al_real     <= cap_real;
    end
  end

  assign beat_dv  = al_rise_ctl;
  assign beat_er  = al_rise_ctl ^ al_fall_ctl;
  assign beat_dat = {al_fall_dat, al_rise_dat};
  assign cnt_next = cnt + 16'd1;

  // The held beat is emitted while the aligned beat supplies its successor's dv, so tlast is known in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SYNC;
      hold_dat      <= '0;
      err_acc       <= 1'b0;
      cnt           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      case (state)
        SYNC: begin
          if (al_real && !beat_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        IDLE: begin
          if (beat_dv) begin
            state    <= ACTIVE;
            hold_dat <= beat_dat;
            err_acc  <= beat_er;
          end
        end
        ACTIVE: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= hold_dat;
          cnt           <= cnt_next;
          if (!beat_dv) begin
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= err_acc;
            state        <= IDLE;
            cnt          <= '0;
          end else if (cnt_next == 16'(MAX_LEN)) begin
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= 1'b1;
            state        <= DROP;
          end else begin
            hold_dat <= beat_dat;
            err_acc  <= err_acc | beat_er;
          end
        end
        DROP: begin
          if (!beat_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

`ifdef DDR_RX_CAPTURE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errors <= '0;
    end else if (m_axis_tvalid && m_axis_tlast) begin
      stat_frames <= stat_frames + 32'd1;
      if (m_axis_tuser) stat_errors <= stat_errors + 32'd1;
    end
  end
`endif

endmodule
